// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: direct-mapped single-word-line read cache in front of a fixed-latency pipelined memory
module cache_fill_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int MEM_LAT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_hit,
    output logic [ADDR_W-1:0] mem_addr_req,
    input  logic              mem_hit_ret,
    input  logic [ADDR_W-1:0] mem_addr_ret,
    input  logic [DATA_W-1:0] mem_data_ret,
    output logic [15:0]       miss_count,
    output logic              ret_err
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [MEM_LAT-1:0] trk_v_q;
    logic [ADDR_W-1:0]  trk_a_q [MEM_LAT];
    logic               ready_q;
    logic               resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               mem_hit_q, mem_hit_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        miss_q, miss_d;
    logic               err_q, err_d;
    logic               head_v, acc, hit, miss_issue;
    logic [ADDR_W-1:0]  head_a;
    logic [INDEX_W-1:0] idx, f_idx;

    assign head_v       = trk_v_q[MEM_LAT-1];
    assign head_a       = trk_a_q[MEM_LAT-1];
    assign f_idx        = head_a[INDEX_W-1:0];
    assign idx          = req_addr[INDEX_W-1:0];
    // a fill due at the next edge owns the response slot, so hold off new lookups
    assign req_ready    = ready_q && !head_v;
    assign acc          = req_valid && req_ready;
    assign hit          = valid_q[idx] && tag_q[idx] == req_addr[ADDR_W-1:INDEX_W];
    assign miss_issue   = acc && !hit;
    assign resp_valid   = resp_valid_q;
    assign resp_addr    = resp_addr_q;
    assign resp_data    = resp_data_q;
    assign mem_hit      = mem_hit_q;
    assign mem_addr_req = mem_addr_q;
    assign miss_count   = miss_q;
    assign ret_err      = err_q;

    // next-state: fill response wins the slot, otherwise a hit responds; misses go to memory
    always_comb begin
        resp_valid_d = head_v || (acc && hit);
        resp_addr_d  = head_v ? head_a : (acc && hit) ? req_addr : resp_addr_q;
        resp_data_d  = head_v ? mem_data_ret : (acc && hit) ? data_q[idx] : resp_data_q;
        mem_hit_d    = !miss_issue;
        mem_addr_d   = miss_issue ? req_addr : '0;
        miss_d       = (miss_issue && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
        err_d        = err_q || (head_v && (mem_hit_ret || mem_addr_ret != head_a));
        valid_d        = valid_q;
        valid_d[f_idx] = valid_q[f_idx] | head_v;
    end

    // control state; the tracker mirrors each issued miss until its data returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            trk_v_q      <= '0;
            for (int i = 0; i < MEM_LAT; i++) trk_a_q[i] <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
            mem_hit_q    <= 1'b1;
            mem_addr_q   <= '0;
            miss_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            trk_v_q      <= {trk_v_q[MEM_LAT-2:0], !mem_hit_q};
            trk_a_q[0]   <= mem_addr_q;
            for (int i = 1; i < MEM_LAT; i++) trk_a_q[i] <= trk_a_q[i-1];
            ready_q      <= 1'b1;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            mem_hit_q    <= mem_hit_d;
            mem_addr_q   <= mem_addr_d;
            miss_q       <= miss_d;
            err_q        <= err_d;
        end
    end

    // tag/data array written on fills with the tracked address, not the returned one
    always_ff @(posedge clk) begin
        if (head_v) begin
            tag_q[f_idx]  <= head_a[ADDR_W-1:INDEX_W];
            data_q[f_idx] <= mem_data_ret;
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench with a behavioural cache model and a fixed-latency memory
module tb_cache_fill_ctrl;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int IW = 6;
    localparam int L  = 6;

    logic          clk = 0, reset = 0, req_valid = 0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready, resp_valid, mem_hit, ret_err;
    logic [AW-1:0] resp_addr, mem_addr_req, mem_addr_ret;
    logic [DW-1:0] resp_data, mem_data_ret;
    logic          mem_hit_ret;
    logic [15:0]   miss_count;

    cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_data(resp_data),
        .mem_hit(mem_hit), .mem_addr_req(mem_addr_req), .mem_hit_ret(mem_hit_ret),
        .mem_addr_ret(mem_addr_ret), .mem_data_ret(mem_data_ret),
        .miss_count(miss_count), .ret_err(ret_err));

    always #5 clk = ~clk;

    // memory: fixed-latency pipe, never reset, so stale returns survive a DUT reset
    logic [L-1:0]  p_hit = '1;
    logic [AW-1:0] p_addr [L];
    logic          bad_mode = 0;
    logic [DW-1:0] mem_arr [1<<AW];
    always @(posedge clk) begin
        p_hit     <= {p_hit[L-2:0], mem_hit};
        p_addr[0] <= mem_addr_req;
        for (int i = 1; i < L; i++) p_addr[i] <= p_addr[i-1];
    end
    assign mem_hit_ret  = p_hit[L-1];
    assign mem_addr_ret = (bad_mode && !p_hit[L-1]) ? '1 : p_addr[L-1];
    assign mem_data_ret = mem_arr[p_addr[L-1]];

    logic rst_at_edge = 0;
    always @(posedge clk) rst_at_edge <= reset;

    typedef struct {int due; logic [AW-1:0] a; logic [DW-1:0] d;} rsp_t;
    typedef struct {int fe; logic [AW-1:0] a;} fill_t;
    rsp_t              sb[$];
    fill_t             fq[$];
    logic [(1<<IW)-1:0] mv = '0;
    logic [AW-IW-1:0]  mt [1<<IW];
    int                n = 0, checks = 0, errors = 0, mc = 0, wc = 0;
    logic              em = 0, exp_mh = 1, acc_flag = 0, done = 0;
    logic [AW-1:0]     exp_ma = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, n, act, exp);
        end
    endtask

    // monitor + reference model: intervals are counted at negedges; the next posedge is edge n+1
    always @(negedge clk) begin : mon
        logic          armed, rdy, hit, fdue;
        int            fi;
        logic [AW-1:0] a;
        n++;
        armed = rst_at_edge && reset;
        if (!reset) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_addr", resp_addr, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_mem_hit", mem_hit, 1);
            chk("rst_mem_addr", mem_addr_req, 0);
            chk("rst_miss_count", miss_count, 0);
            chk("rst_ret_err", ret_err, 0);
            chk("rst_req_ready", req_ready, 0);
            sb.delete(); fq.delete();
            mv = '0; mc = 0; em = 0; exp_mh = 1; exp_ma = '0; acc_flag = 0; wc = 0;
        end else begin
            fi = -1;
            foreach (sb[i]) if (sb[i].due == n) fi = i;
            if (fi >= 0) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_addr", resp_addr, sb[fi].a);
                chk("resp_data", resp_data, sb[fi].d);
                sb.delete(fi);
            end else chk("resp_valid_idle", resp_valid, 0);
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due < n) begin
                    chk("resp_missing_due", sb[i].due, n);
                    sb.delete(i);
                end
            chk("mem_hit", mem_hit, exp_mh);
            chk("mem_addr_req", mem_addr_req, exp_ma);
            chk("miss_count", miss_count, mc);
            chk("ret_err", ret_err, em);
            fdue = 0;
            foreach (fq[i]) if (fq[i].fe == n + 1) fdue = 1;
            rdy = armed && !fdue;
            chk("req_ready", req_ready, rdy);
            acc_flag = req_valid && rdy;
            wc = (req_valid && !acc_flag) ? wc + 1 : 0;
            chk("stall_bound", wc < 40, 1);
            exp_mh = 1; exp_ma = '0;
            if (acc_flag) begin
                a = req_addr;
                hit = mv[a[IW-1:0]] && mt[a[IW-1:0]] == a[AW-1:IW];
                if (hit) sb.push_back('{n + 1, a, mem_arr[a]});
                else begin
                    exp_mh = 0; exp_ma = a;
                    if (mc < 65535) mc++;
                    sb.push_back('{n + L + 2, a, mem_arr[a]});
                    fq.push_back('{n + L + 2, a});
                end
            end
            for (int i = fq.size() - 1; i >= 0; i--)
                if (fq[i].fe == n + 1) begin
                    mv[fq[i].a[IW-1:0]] = 1;
                    mt[fq[i].a[IW-1:0]] = fq[i].a[AW-1:IW];
                    if (bad_mode) em = 1;
                    fq.delete(i);
                end
            if (done) begin
                chk("sb_drained", sb.size(), 0);
                chk("fills_drained", fq.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic req(input logic [AW-1:0] a);
        req_valid = 1; req_addr = a;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (acc_flag) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int c);
        req_valid = 0;
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = $urandom;
        mem_arr[15'h41] = 32'hDEADBEEF;
        mem_arr[15'h81] = 32'h12345678;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        idle(1);
        req(15'h41); idle(10);
        req(15'h41); idle(3);
        req(15'h81); idle(10);
        req(15'h41); idle(10);
        req(15'h02);
        for (int i = 0; i < 12; i++) req(15'h41);
        idle(10);
        bad_mode = 1; req(15'h03); idle(10);
        bad_mode = 0; req(15'h03); idle(3);
        req(15'h05); idle(2);
        reset = 0; idle(3);
        reset = 1; idle(12);
        req(15'h41); idle(10);
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            req(AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7)));
        end
        idle(20);
        done = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
endmodule
